// File: rtl/mem_sched_pkg.sv
// Shared types for the accumulator read scheduler.
// Contents: scheduler FSM state encoding, queued command payload, and the
// read-controller occupancy window helper.
package mem_sched_pkg;

  // Command payload widths (match the scheduler's default parameters).
  localparam int unsigned CMD_ID_W   = 1;
  localparam int unsigned CMD_ADDR_W = 8;
  localparam int unsigned CMD_NUM_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [CMD_ID_W-1:0]   id;
    logic [CMD_ADDR_W-1:0] base_addr;
    logic [CMD_NUM_W-1:0]  num_row;
  } cmd_t;

  // Occupancy window of the skewed read controller: 2*n_eff + SYS_ROW + 2,
  // with the row count clamped to the accumulator depth.
  function automatic int unsigned rd_window(input logic [CMD_NUM_W-1:0] n,
                                            input int unsigned sys_row,
                                            input int unsigned accum_row);
    int unsigned n_eff;
    n_eff = (32'(n) > accum_row) ? accum_row : 32'(n);
    return 2 * n_eff + sys_row + 2;
  endfunction

endpackage

// File: rtl/sched_cmd_fifo.sv
// Synchronous command FIFO for the read scheduler.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, wdata     write strobe and command (ignored while full)
//   pop             remove head entry (ignored while empty)
//   head_c          current head entry (direct read of storage)
//   head_nxt_c      entry behind the head, valid when count > 1
//   full, empty     registered status flags
//   count           registered occupancy
module sched_cmd_fifo
  import mem_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  cmd_t                     wdata,
  input  logic                     pop,
  output cmd_t                     head_c,
  output cmd_t                     head_nxt_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CNT_W-1:0] count_d;

  // Guarded strobes and next occupancy.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    count_d = count + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Storage, pointers and registered status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_d;
      full  <= (count_d == CNT_W'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  assign head_c     = mem[rd_ptr];
  assign head_nxt_c = mem[rd_ptr + PTR_W'(1)];

endmodule

// File: rtl/mem_rd_sched.sv
// Read scheduler in front of the skewed accumulator read controller.
// Round-robin arbitrates NUM_REQ requesters into a command FIFO, issues one
// start pulse per command, holds base_addr/num_row for the controller's
// occupancy window, then strobes completion with the requester id.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   req_valid/req_ready            per-requester handshake (ready one-hot)
//   req_base_addr, req_num_row     per-requester command payload
//   rd_en_in                       single-cycle start pulse to the controller
//   base_addr, num_row             command held for the controller window
//   busy                           FSM active or commands queued
//   done_valid, done_id            completion strobe and requester id
module mem_rd_sched
  import mem_sched_pkg::*;
#(
  parameter int unsigned SYS_ROW    = 16,
  parameter int unsigned SYS_COL    = 16,
  parameter int unsigned DATA_WIDTH = CMD_NUM_W,
  parameter int unsigned ACCUM_SIZE = 4096,
  parameter int unsigned ADDR_WIDTH = CMD_ADDR_W,
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    req_base_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_num_row,
  output logic                                  rd_en_in,
  output logic [ADDR_WIDTH-1:0]                 base_addr,
  output logic [DATA_WIDTH-1:0]                 num_row,
  output logic                                  busy,
  output logic                                  done_valid,
  output logic [$clog2(NUM_REQ)-1:0]            done_id
);

  localparam int unsigned ACCUM_ROW = ACCUM_SIZE / SYS_COL;
  localparam int unsigned ID_W      = $clog2(NUM_REQ);
  localparam int unsigned CNT_W     = $clog2(2 * ACCUM_ROW + SYS_ROW + 3);
  localparam int unsigned FCNT_W    = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_ISSUE = 2'(ISSUE);
  localparam logic [1:0] ST_RUN   = 2'(RUN);
  localparam logic [1:0] ST_DONE  = 2'(DONE);

  // Arbiter
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    rr_next;
  logic [ID_W-1:0]    gid;
  logic               gfound;
  logic [NUM_REQ-1:0] grant;
  int unsigned        idx;

  // FIFO
  logic              push;
  logic              pop;
  cmd_t              wcmd;
  cmd_t              head;
  cmd_t              head_nxt;
  logic              full;
  logic              empty;
  logic [FCNT_W-1:0] fcount;
  logic [FCNT_W-1:0] fcount_d;

  // FSM and registered-output next values
  logic [1:0]            state;
  logic [1:0]            state_d;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_d;
  cmd_t                  out_cmd;
  logic                  rd_en_d;
  logic [ADDR_WIDTH-1:0] base_d;
  logic [DATA_WIDTH-1:0] num_d;
  logic                  busy_d;
  logic                  done_d;
  logic [ID_W-1:0]       done_id_d;

  // Round-robin pick starting at rr_ptr; no grant while full or in reset.
  always_comb begin
    grant  = '0;
    gid    = '0;
    gfound = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + 32'(k)) % NUM_REQ;
      if (!gfound && req_valid[ID_W'(idx)]) begin
        gfound = 1'b1;
        gid    = ID_W'(idx);
      end
    end
    if (gfound && !full && !rst) begin
      grant[gid] = 1'b1;
    end
  end

  assign req_ready = grant;
  assign push      = |grant;
  assign rr_next   = (32'(gid) == NUM_REQ - 1) ? '0 : gid + ID_W'(1);

  always_comb begin
    wcmd           = '0;
    wcmd.id        = CMD_ID_W'(gid);
    wcmd.base_addr = CMD_ADDR_W'(req_base_addr[gid]);
    wcmd.num_row   = CMD_NUM_W'(req_num_row[gid]);
  end

  sched_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .wdata      (wcmd),
    .pop        (pop),
    .head_c     (head),
    .head_nxt_c (head_nxt),
    .full       (full),
    .empty      (empty),
    .count      (fcount)
  );

  // Next state, window counter and next output values. Outputs are computed
  // from the upcoming state; on a pop the upcoming head is the entry behind
  // the current head.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          state_d = (head.num_row == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_W'(rd_window(head.num_row, SYS_ROW, ACCUM_ROW) - 1);
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cnt == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        pop = 1'b1;
        if (fcount > FCNT_W'(1)) begin
          state_d = (head_nxt.num_row == '0) ? ST_DONE : ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    out_cmd   = pop ? head_nxt : head;
    fcount_d  = fcount + FCNT_W'(push) - FCNT_W'(pop);
    rd_en_d   = (state_d == ST_ISSUE);
    done_d    = (state_d == ST_DONE);
    done_id_d = done_d ? ID_W'(out_cmd.id) : '0;
    base_d    = (state_d != ST_IDLE) ? ADDR_WIDTH'(out_cmd.base_addr) : '0;
    num_d     = (state_d != ST_IDLE) ? DATA_WIDTH'(out_cmd.num_row) : '0;
    busy_d    = (state_d != ST_IDLE) || (fcount_d != '0);
  end

  // State, counter, arbiter pointer and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      rr_ptr     <= '0;
      rd_en_in   <= 1'b0;
      base_addr  <= '0;
      num_row    <= '0;
      busy       <= 1'b0;
      done_valid <= 1'b0;
      done_id    <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      if (push) begin
        rr_ptr <= rr_next;
      end
      rd_en_in   <= rd_en_d;
      base_addr  <= base_d;
      num_row    <= num_d;
      busy       <= busy_d;
      done_valid <= done_d;
      done_id    <= done_id_d;
    end
  end

endmodule

// File: doc/mem_rd_sched.md
Name: mem_rd_sched

Overview:
Scheduler in front of the skewed accumulator read controller. It arbitrates between NUM_REQ requesters that want to stream tiles out of the accumulator, for example output drain and partial-sum reload. Granted commands are queued in a small FIFO. The block issues one start pulse per command to the read controller, holds base_addr and num_row stable for the controller's whole occupancy window, and then reports completion with the requester id.

Parameters:
SYS_ROW, 16, systolic rows; the skew drain length of the read controller.
SYS_COL, 16, systolic columns.
DATA_WIDTH, 16, width of the num_row field.
ACCUM_SIZE, 4096, accumulator entries; ACCUM_ROW = ACCUM_SIZE/SYS_COL (local).
ADDR_WIDTH, 8, accumulator row address width.
NUM_REQ, 2, number of requesters; minimum 2.
FIFO_DEPTH, 4, command queue depth; power of 2.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester command valid
req_ready  out  NUM_REQ  per-requester command accepted this cycle
req_base_addr  in  NUM_REQ x ADDR_WIDTH  start row per requester
req_num_row  in  NUM_REQ x DATA_WIDTH  rows to read per requester
rd_en_in  out  1  single-cycle start pulse to the read controller
base_addr  out  ADDR_WIDTH  base address to the read controller
num_row  out  DATA_WIDTH  row count to the read controller
busy  out  1  FSM not IDLE or FIFO not empty
done_valid  out  1  single-cycle completion strobe
done_id  out  $clog2(NUM_REQ)  requester id of the completed command

Behaviour:
- Reset (asynchronous, active-high) clears the FIFO, the FSM (to IDLE), the window counter and the round-robin pointer. All outputs are 0, except req_ready, which is 1 on the first cycle after reset deasserts.
- Reset mid-operation aborts the command silently: no done is produced. The read controller must be reset concurrently.
- Arbiter:
  - Round-robin over the valid requesters, starting at the index after the last grant. After reset, req0 has highest priority.
  - req_ready is one-hot and is 0 for every requester while the FIFO is full.
  - Full is computed from the registered count, so a pop in the same cycle does not free a slot.
  - On valid & ready, {id, base_addr, num_row} is written at the clock edge and becomes visible at the head on the next cycle.
  - The pointer advances only on an accepted grant.
- FSM states: IDLE, ISSUE, RUN, DONE.
  - IDLE: if the FIFO is non-empty, go to ISSUE. If the head has num_row == 0, go directly to DONE with no pulse.
  - ISSUE (1 cycle): rd_en_in = 1. Load the counter with W-1, where W = 2*n_eff + SYS_ROW + 2 and n_eff = min(head num_row, ACCUM_ROW). Go to RUN.
  - RUN: decrement the counter each cycle; when the counter is 0, go to DONE. RUN lasts exactly W cycles.
  - DONE (1 cycle): done_valid = 1 and done_id = head id. Pop the FIFO. If a second entry exists (count > 1), go to ISSUE (or DONE for num_row == 0); otherwise go to IDLE.
- base_addr and num_row are driven from the FIFO head during ISSUE, RUN and DONE. They are 0 in IDLE.
- The counter width is $clog2(2*ACCUM_ROW + SYS_ROW + 3). num_row > ACCUM_ROW is clamped for W only and is passed through unchanged.
- Latency: handshake in cycle C gives rd_en_in in cycle C+2 when the FSM is idle.
- Simultaneous push and pop are both honoured; the count is unchanged.

Decomposition:
- Package mem_sched_pkg: sched_state_e enum (IDLE/ISSUE/RUN/DONE); cmd_t struct {id, base_addr, num_row}; function rd_window(n) returning W.
- Sub-module sched_cmd_fifo: synchronous FIFO of cmd_t, parameterised by FIFO_DEPTH, with full, empty and count outputs.
- The arbiter and FSM live in the top module.

Test Plan:
1. Single command: req0 base=0x10, num_row=4, handshake in cycle C. Expect rd_en_in only at C+2, base_addr=0x10 and num_row=4 held through C+29, done_valid with done_id=0 at C+29, busy=0 at C+30.
2. Contention: req0 and req1 valid every cycle from reset. Expect grants in the order 0,1,0,1. req_ready = 0 once 4 entries are queued. Dones arrive in grant order, and the DONE→ISSUE transitions have no IDLE gap.
3. Zero and clamp: num_row=0 produces no rd_en_in and done 2 cycles after the handshake. num_row=300 (ACCUM_ROW=256) gives W=530 and num_row output=300.
4. Full FIFO with pop: FIFO at 4 entries during a DONE cycle. Expect req_ready=0 that cycle and req_ready=1 the next cycle.
5. Reset in RUN: assert rst at counter=5. Expect all outputs 0 immediately with no done_valid. After release, req0 wins a tie with req1.
